// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;

    localparam int DEFAULT_CNT_W  = 26;
    localparam int DEFAULT_PERIOD = 50000;   // 1 ms at 50 MHz
    localparam int DEFAULT_HIGH   = 25000;
    localparam int MIN_PERIOD     = 2;       // shorter active periods are clamped up to this

    // Width of the channel-select field; never narrower than one bit.
    function automatic int ch_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period/high counter with pending and active settings.
// Settings are only swapped at a period boundary (wrap or SYNC), so a running
// period is never cut short and the counter can never pass the active period.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int DEF_PERIOD = DEFAULT_PERIOD,
    parameter int DEF_HIGH   = DEFAULT_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt, pend_p, pend_h, act_p, act_h;
    logic [CNT_W-1:0] nxt_pend_p, nxt_pend_h, eff_p, new_p, new_h, new_eff, cnt_nxt;
    logic             wrap, out_nxt;

    // Next-state: a same-edge write is forwarded straight into the active pair on wrap.
    always_comb begin
        nxt_pend_p = we ? cfg_period : pend_p;
        nxt_pend_h = we ? cfg_high   : pend_h;
        eff_p      = (act_p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : act_p;
        wrap       = sync || (cnt >= eff_p - 1'b1);
        new_p      = wrap ? nxt_pend_p : act_p;
        new_h      = wrap ? nxt_pend_h : act_h;
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        new_eff    = (new_p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : new_p;
        // Low phase first; H=0 pins low, H>=P pins high (avoids P-H underflow).
        if (new_h == '0)
            out_nxt = 1'b0;
        else if (new_h >= new_eff)
            out_nxt = 1'b1;
        else
            out_nxt = (cnt_nxt >= new_eff - new_h);
    end

    // Pending settings accept writes whether or not the channel is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_p <= CNT_W'(DEF_PERIOD);
            pend_h <= CNT_W'(DEF_HIGH);
        end else begin
            pend_p <= nxt_pend_p;
            pend_h <= nxt_pend_h;
        end
    end

    // Counter, active settings and registered outputs; all hold while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            act_p   <= CNT_W'(DEF_PERIOD);
            act_h   <= CNT_W'(DEF_HIGH);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            cnt     <= cnt_nxt;
            act_p   <= new_p;
            act_h   <= new_h;
            clk_out <= out_nxt;
            tick    <= wrap;
        end else begin
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// N_CH independent programmable clock dividers sharing one config port and SYNC.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int DEF_PERIOD = DEFAULT_PERIOD,
    parameter int DEF_HIGH   = DEFAULT_HIGH,
    localparam int CH_W      = ch_sel_w(N_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   EN,
    input  logic              SYNC,
    input  logic              CFG_WE,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [CNT_W-1:0]  CFG_PERIOD,
    input  logic [CNT_W-1:0]  CFG_HIGH,
    output logic [N_CH-1:0]   CLK_OUT,
    output logic [N_CH-1:0]   TICK
);

    logic [N_CH-1:0] ch_we;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Decode the write target; selects beyond N_CH match no channel.
        assign ch_we[g] = CFG_WE && (CFG_CH == CH_W'(g));

        clk_div_ch #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk        (CLK),
            .rst        (RST),
            .en         (EN[g]),
            .sync       (SYNC),
            .we         (ch_we[g]),
            .cfg_period (CFG_PERIOD),
            .cfg_high   (CFG_HIGH),
            .clk_out    (CLK_OUT[g]),
            .tick       (TICK[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomized self-checking bench for prog_clk_divider against a period/phase model.
module tb_prog_clk_divider;

    localparam int N = 4;
    localparam int W = 26;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] EN;
    logic         SYNC;
    logic         CFG_WE;
    logic [1:0]   CFG_CH;
    logic [W-1:0] CFG_PERIOD, CFG_HIGH;
    logic [N-1:0] CLK_OUT, TICK;

    prog_clk_divider dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_PERIOD(CFG_PERIOD), .CFG_HIGH(CFG_HIGH), .CLK_OUT(CLK_OUT), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: each channel is "position within period" plus settings.
    int unsigned m_cnt[N], m_pp[N], m_ph[N], m_ap[N], m_ah[N];
    logic [N-1:0] m_co, m_tk;

    function automatic int unsigned eff(input int unsigned p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic lvl(input int unsigned c, input int unsigned p, input int unsigned h);
        int unsigned pe = eff(p);
        if (h == 0) return 1'b0;
        if (h >= pe) return 1'b1;
        return (c >= pe - h);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_pp[i] = 50000; m_ph[i] = 25000;
            m_ap[i] = 50000; m_ah[i] = 25000;
        end
        m_co = '0; m_tk = '0;
    endtask

    task automatic model_step();
        int unsigned np, nh;
        for (int i = 0; i < N; i++) begin
            np = m_pp[i]; nh = m_ph[i];
            if (CFG_WE && CFG_CH == i) begin np = CFG_PERIOD; nh = CFG_HIGH; end
            if (EN[i]) begin
                if (SYNC || m_cnt[i] == eff(m_ap[i]) - 1) begin
                    m_cnt[i] = 0; m_ap[i] = np; m_ah[i] = nh; m_tk[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1; m_tk[i] = 1'b0;
                end
                m_co[i] = lvl(m_cnt[i], m_ap[i], m_ah[i]);
            end else begin
                m_tk[i] = 1'b0;
            end
            m_pp[i] = np; m_ph[i] = nh;
        end
    endtask

    // One clock: model consumes current inputs, DUT sampled 1 time unit after the edge.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        chk("clk_out", CLK_OUT, m_co);
        chk("tick", TICK, m_tk);
        CFG_WE = 1'b0;
        SYNC   = 1'b0;
    endtask

    task automatic wr(input int ch, input int p, input int h);
        CFG_WE = 1'b1; CFG_CH = 2'(ch); CFG_PERIOD = W'(p); CFG_HIGH = W'(h);
    endtask

    int rise0, fall0, tick0, tick1_first;
    int nt1, nh1, nt2, nh2, t0, t1, tw;
    logic prev0, held3;

    initial begin
        RST = 1'b1; EN = '0; SYNC = 1'b0; CFG_WE = 1'b0; CFG_CH = '0;
        CFG_PERIOD = '0; CFG_HIGH = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_clk_out", CLK_OUT, 0);
        chk("reset_tick", TICK, 0);
        RST = 1'b0;
        EN  = '1;

        // Default 50000/25000 period; ch1 and ch2 get new settings mid-period.
        rise0 = 0; fall0 = 0; tick0 = 0; tick1_first = 0; prev0 = 1'b0;
        for (int k = 1; k <= 50000; k++) begin
            if (k == 20000) wr(1, 10, 3);
            if (k == 30000) wr(2, 1, 0);
            cycle();
            if (CLK_OUT[0] && !prev0 && rise0 == 0) rise0 = k;
            if (!CLK_OUT[0] && prev0 && fall0 == 0) fall0 = k;
            if (TICK[0] && tick0 == 0) tick0 = k;
            if (TICK[1] && tick1_first == 0) tick1_first = k;
            prev0 = CLK_OUT[0];
        end
        chk("def_rise_edge", rise0, 25000);
        chk("def_fall_edge", fall0, 50000);
        chk("def_tick_edge", tick0, 50000);
        chk("ch1_old_period_done", tick1_first, 50000);

        // ch1 now 10/3, ch2 clamped to period 2 constant low.
        nt1 = 0; nh1 = 0; nt2 = 0; nh2 = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            nt1 += TICK[1]; nh1 += CLK_OUT[1];
            nt2 += TICK[2]; nh2 += CLK_OUT[2];
        end
        chk("ch1_ticks_30", nt1, 3);
        chk("ch1_high_30", nh1, 9);
        chk("ch2_ticks_30", nt2, 15);
        chk("ch2_high_30", nh2, 0);

        // ch2 to P=4 H=4: constant high.
        wr(2, 4, 4);
        repeat (3) cycle();
        nt2 = 0; nh2 = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            nt2 += TICK[2]; nh2 += CLK_OUT[2];
        end
        chk("ch2_const_high", nh2, 16);
        chk("ch2_ticks_16", nt2, 4);

        // SYNC with ch1 written on the same edge.
        wr(3, 12, 6); cycle();
        wr(0, 6, 3);  cycle();
        wr(1, 9, 4); SYNC = 1'b1; cycle();
        chk("sync_all_tick", TICK, 4'hF);
        t0 = 0; t1 = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (TICK[0] && t0 == 0) t0 = k;
            if (TICK[1] && t1 == 0) t1 = k;
        end
        chk("sync_next_tick_ch0", t0, 6);
        chk("sync_next_tick_ch1", t1, 9);

        // Pause ch3 for 5 cycles at cnt=2.
        for (int k = 0; k < 20 && m_cnt[3] != 2; k++) cycle();
        chk("ch3_reached_cnt2", m_cnt[3], 2);
        held3 = CLK_OUT[3];
        EN[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("ch3_hold_tick", TICK[3], 0);
            chk("ch3_hold_out", CLK_OUT[3], held3);
        end
        EN[3] = 1'b1;
        tw = 0;
        for (int k = 1; k <= 40 && tw == 0; k++) begin
            cycle();
            if (TICK[3]) tw = k;
        end
        chk("ch3_resume_wrap", tw, 10);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) EN[i] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 14)), int'($urandom_range(0, 16)));
            SYNC = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // Asynchronous reset mid-period with a pending P=8 write.
        EN = '1;
        wr(0, 8, 2); cycle();
        repeat (3) cycle();
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_clk_out", CLK_OUT, 0);
        chk("async_rst_tick", TICK, 0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        nt1 = 0; nh1 = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            nt1 += TICK[0]; nh1 += CLK_OUT[0];
        end
        chk("post_rst_no_tick", nt1, 0);
        chk("post_rst_low", nh1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
